// File: rtl/uart_dev_pkg.sv
// uart_dev_pkg: shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets (Addr[1:0]), STATUS/CTRL bit positions, the
// transmit FSM state type and the bit-period helper.
package uart_dev_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_DIV    = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // A programmed period of 0 is treated as 1 cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_dev_if.sv
// uart_tx_dev_if: word-addressed register bus between the system bridge
// (master) and the UART transmitter (slave).
//   Addr : word address, only [1:0] decoded by the device
//   WE   : write strobe, sampled on the rising clock edge
//   Din  : write data
//   Dout : read data, combinational from Addr
interface uart_tx_dev_if;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8-bit synchronous FIFO holding bytes waiting to be sent.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push_i     : write wdata_i; ignored when full unless a pop happens too
//   pop_i      : discard the head entry; ignored when empty
//   rdata_o    : head entry
//   full_o, empty_o, count_o : occupancy
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [7:0]                   wdata_i,
  input  logic                         pop_i,
  output logic [7:0]                   rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot this same edge, so a push to a full FIFO still fits.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter behind the system bridge.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : register bus (DATA/STATUS/CTRL/DIV selected by Addr[1:0])
//   IRQ        : level interrupt, IRQEN & FIFO empty & line idle
//   txd        : serial output, idles high
module uart_tx_dev
  import uart_dev_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DIV_RESET = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_dev_if.slave  bus,
  output logic          IRQ,
  output logic          txd
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  tx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   timer_q, timer_d;
  logic          txd_q, txd_d;

  logic          push, pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic [7:0]    count8;
  logic          wr_status, wr_ctrl, wr_div;
  logic          bit_end, busy, txen, irqen;
  logic          unused_bits;

  assign unused_bits = ^{bus.Addr[29:2], bus.Din[31:16]};

  assign wr_status = bus.WE && (bus.Addr[1:0] == UART_STATUS);
  assign wr_ctrl   = bus.WE && (bus.Addr[1:0] == UART_CTRL);
  assign wr_div    = bus.WE && (bus.Addr[1:0] == UART_DIV);
  assign push      = bus.WE && (bus.Addr[1:0] == UART_DATA);

  assign txen    = ctrl_q[CTRL_TXEN];
  assign irqen   = ctrl_q[CTRL_IRQEN];
  assign busy    = (state_q != IDLE);
  assign bit_end = (timer_q == 16'd0);
  assign count8  = 8'(fifo_count);
  assign IRQ     = irqen & fifo_empty & ~busy;
  assign txd     = txd_q;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (bus.Din[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register file and read mux
  always_comb begin
    ctrl_d = wr_ctrl ? bus.Din[1:0] : ctrl_q;
    div_d  = wr_div  ? bus.Din[15:0] : div_q;
    ovf_d  = ovf_q;
    if (wr_status)                        ovf_d = 1'b0;
    else if (push && fifo_full && !pop)   ovf_d = 1'b1;
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr[1:0])
      UART_STATUS: begin
        bus.Dout[ST_BUSY]         = busy;
        bus.Dout[ST_FULL]         = fifo_full;
        bus.Dout[ST_EMPTY]        = fifo_empty;
        bus.Dout[ST_OVF]          = ovf_q;
        bus.Dout[ST_CNT_LSB +: 4] = count8[3:0];
      end
      UART_CTRL: bus.Dout[1:0]  = ctrl_q;
      UART_DIV:  bus.Dout[15:0] = div_q;
      default:   bus.Dout = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      div_q  <= 16'(DIV_RESET);
      ovf_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      ovf_q  <= ovf_d;
    end
  end

  // Transmit FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Transmit FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transmit FSM: outputs. txd is registered from the next state so it
  // changes on the same edge as the state and never glitches.
  always_comb begin
    pop = txen && !fifo_empty &&
          ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Bit timer, shift register, bit index. The timer reloads from DIV only
  // at a bit start, so a DIV write never alters the bit in flight.
  always_comb begin
    timer_d   = timer_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    if (state_q == IDLE) begin
      if (pop) timer_d = eff_div(div_q) - 16'd1;
    end else if (bit_end) begin
      timer_d = eff_div(div_q) - 16'd1;
    end else begin
      timer_d = timer_q - 16'd1;
    end
    if (pop) begin
      shift_d = fifo_head;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q   <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed + randomized bench for uart_tx_dev. Expected txd
// waveforms are built from frame rules (start 0, 8 data bits LSB first,
// stop 1, each bit lasting the programmed period) into a bit queue.
module tb_uart_tx_dev;
  import uart_dev_pkg::*;

  localparam int DEPTH     = 4;
  localparam int DIV_RESET = 16;

  logic clk = 1'b0;
  logic reset;
  logic IRQ, txd;

  uart_tx_dev_if bus ();

  uart_tx_dev #(.DEPTH(DEPTH), .DIV_RESET(DIV_RESET)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (IRQ),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit wave[$];

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = {28'd0, a};
    bus.Din  = d;
    bus.WE   = 1'b1;
    step();
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = {28'd0, a};
    #1;
    d = bus.Dout;
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic [31:0] status_word(input bit bsy, input bit full,
                                              input bit empty, input bit ovf,
                                              input int count);
    return (32'(count) << 4) | (32'(ovf) << 3) | (32'(empty) << 2) |
           (32'(full) << 1) | 32'(bsy);
  endfunction

  // Start bit and bit 0 last d0 cycles, the remaining bits last d1 cycles.
  task automatic add_frame(input logic [7:0] b, input int d0, input int d1);
    bit lvl;
    int len;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else             lvl = b[k-1];
      len = (k <= 1) ? eff(d0) : eff(d1);
      repeat (len) wave.push_back(lvl);
    end
  endtask

  // Called right after the edge that starts transmission; compares every
  // cycle to the queued waveform, optionally injecting one register write.
  task automatic run_wave(input bit irqen, input int inj_j, input logic [1:0] inj_a,
                          input logic [31:0] inj_d, input string tag);
    int n;
    n = wave.size();
    for (int j = 1; j <= n; j++) begin
      if (j == inj_j) begin
        bus.Addr = {28'd0, inj_a};
        bus.Din  = inj_d;
        bus.WE   = 1'b1;
      end
      step();
      bus.WE   = 1'b0;
      bus.Addr = {28'd0, UART_STATUS};
      #1;
      chk($sformatf("%s_txd[%0d]", tag, j), 32'(txd), 32'(wave[j-1]));
      chk($sformatf("%s_irq[%0d]", tag, j), 32'(IRQ), 32'd0);
      chk($sformatf("%s_busy[%0d]", tag, j), 32'(bus.Dout[0]), 32'd1);
    end
    step();
    bus.Addr = {28'd0, UART_STATUS};
    #1;
    chk({tag, "_end_txd"}, 32'(txd), 32'd1);
    chk({tag, "_end_irq"}, 32'(IRQ), 32'(irqen));
    chk({tag, "_end_status"}, bus.Dout, status_word(0, 0, 1, 0, 0));
    wave.delete();
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          d, n, lows;

    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd_held", 32'(txd), 32'd1);
    reset = 1'b0;

    // Reset state
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_irq", 32'(IRQ), 32'd0);
    rd(UART_STATUS, r); chk("rst_status", r, 32'h04);
    rd(UART_CTRL, r);   chk("rst_ctrl", r, 32'h0);
    rd(UART_DIV, r);    chk("rst_div", r, 32'd16);
    rd(UART_DATA, r);   chk("rst_data", r, 32'h0);
    step();

    // Single frame 0x55 at DIV=4
    wr(UART_DIV, 32'd4);
    wr(UART_CTRL, 32'h1);
    rd(UART_DIV, r);  chk("div_rb", r, 32'd4);
    rd(UART_CTRL, r); chk("ctrl_rb", r, 32'h1);
    step();
    add_frame(8'h55, 4, 4);
    wr(UART_DATA, 32'h55);
    run_wave(1'b0, 0, UART_DATA, 32'h0, "f55");

    // DIV=0 behaves as one cycle per bit
    wr(UART_DIV, 32'd0);
    rd(UART_DIV, r); chk("div0_rb", r, 32'd0);
    step();
    b = 8'($urandom);
    add_frame(b, 0, 0);
    wr(UART_DATA, {24'd0, b});
    run_wave(1'b0, 0, UART_DATA, 32'h0, "div0");

    // Random single frames at random periods
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 5));
      b = 8'($urandom);
      wr(UART_DIV, 32'(d));
      add_frame(b, d, d);
      wr(UART_DATA, {24'd0, b});
      run_wave(1'b0, 0, UART_DATA, 32'h0, $sformatf("rnd%0d", i));
    end

    // Overflow with TXEN off, then back-to-back drain
    wr(UART_CTRL, 32'h0);
    wr(UART_DIV, 32'd4);
    for (int v = 1; v <= 5; v++) wr(UART_DATA, 32'(v));
    rd(UART_STATUS, r); chk("ovf_status", r, status_word(0, 1, 0, 1, 4));
    step();
    wr(UART_STATUS, $urandom);
    rd(UART_STATUS, r); chk("ovf_cleared", r, status_word(0, 1, 0, 0, 4));
    step();
    for (int v = 1; v <= 4; v++) add_frame(8'(v), 4, 4);
    wr(UART_CTRL, 32'h1);
    run_wave(1'b0, 0, UART_DATA, 32'h0, "b2b");

    // Random burst of queued bytes
    wr(UART_CTRL, 32'h0);
    n = int'($urandom_range(1, DEPTH));
    d = int'($urandom_range(1, 3));
    wr(UART_DIV, 32'(d));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      add_frame(b, d, d);
      wr(UART_DATA, {24'd0, b});
    end
    rd(UART_STATUS, r); chk("burst_status", r, status_word(0, n == DEPTH, 0, 0, n));
    step();
    wr(UART_CTRL, 32'h1);
    run_wave(1'b0, 0, UART_DATA, 32'h0, "burst");

    // Interrupt behaviour
    wr(UART_DIV, 32'd2);
    wr(UART_CTRL, 32'h3);
    chk("irq_idle", 32'(IRQ), 32'd1);
    add_frame(8'hA3, 2, 2);
    wr(UART_DATA, 32'hA3);
    run_wave(1'b1, 0, UART_DATA, 32'h0, "irqA3");
    wr(UART_CTRL, 32'h1);
    chk("irq_disabled", 32'(IRQ), 32'd0);

    // DIV change in the middle of data bit 0
    wr(UART_DIV, 32'd4);
    b = 8'($urandom);
    add_frame(b, 4, 8);
    wr(UART_DATA, {24'd0, b});
    run_wave(1'b0, 6, UART_DIV, 32'd8, "divchg");

    // Reset in the middle of a frame
    wr(UART_DIV, 32'd4);
    wr(UART_DATA, 32'h00);
    wr(UART_DATA, 32'h11);
    wr(UART_DATA, 32'h22);
    repeat (5) step();
    chk("pre_rst_txd", 32'(txd), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_async_txd", 32'(txd), 32'd1);
    chk("rst_async_irq", 32'(IRQ), 32'd0);
    step();
    step();
    reset = 1'b0;
    rd(UART_STATUS, r); chk("post_rst_status", r, 32'h04);
    rd(UART_CTRL, r);   chk("post_rst_ctrl", r, 32'h0);
    rd(UART_DIV, r);    chk("post_rst_div", r, 32'd16);
    step();
    wr(UART_CTRL, 32'h1);
    lows = 0;
    repeat (40) begin
      step();
      if (txd !== 1'b1) lows++;
    end
    chk("no_residual_frame", 32'(lows), 32'd0);
    rd(UART_STATUS, r); chk("post_rst_idle", r, 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
